// File: rtl/neq_stream_monitor_pkg.sv
// Shared types and helpers for the neq_stream_monitor block.
// Holds the FSM state encoding and the saturating-counter ceiling helper.
package neq_stream_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // All-ones value for a counter of the given width (widths up to 64 bits).
  function automatic logic [63:0] cnt_max(input int unsigned w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/StructuralLogicalNEQ.sv
// N-bit structural not-equal comparator: per-bit XOR feeding an OR chain.
// Purely combinational; neq is 1 when any bit of a differs from b.
module StructuralLogicalNEQ #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         neq
);

  logic [N-1:0] w_diff;
  logic [N:0]   w_any;

  assign w_any[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    xor u_xor (w_diff[i], a[i], b[i]);
    or  u_or  (w_any[i+1], w_any[i], w_diff[i]);
  end

  assign neq = w_any[N];

endmodule

// File: rtl/neq_stream_monitor.sv
// Streaming NEQ monitor: accepts (a,b) pairs, emits a registered a!=b result,
// counts mismatches (saturating) and can halt on the first mismatch.
// Optional first-mismatch capture ports: define NEQ_STREAM_MONITOR_FIRST_CAPTURE_EN.
module neq_stream_monitor
  import neq_stream_monitor_pkg::*;
#(
  parameter int N           = 8,
  parameter int CNT_W       = 16,
  parameter bit HALT_ON_NEQ = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_neq,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             cnt_sat,
  output logic             halted
`ifdef NEQ_STREAM_MONITOR_FIRST_CAPTURE_EN
  ,
  output logic [N-1:0]     first_a,
  output logic [N-1:0]     first_b,
  output logic             first_vld
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  state_t           r_state;
  logic             r_out_valid;
  logic             r_out_neq;
  logic [CNT_W-1:0] r_cnt;

  logic w_neq;
  logic w_accept;
  logic w_mismatch;

  StructuralLogicalNEQ #(.N(N)) u_neq (
    .a   (a),
    .b   (b),
    .neq (w_neq)
  );

  // clear masks in_ready so a coincident pair is never accepted; in_valid
  // stays out of this path so the source may wait on in_ready.
  assign in_ready   = (r_state == RUN) && (!r_out_valid || out_ready) && !clear;
  assign w_accept   = in_valid && in_ready;
  // Gating with w_accept keeps X on unaccepted a/b away from every register.
  assign w_mismatch = w_accept && w_neq;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its peers; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_neq   <= 1'b0;
      r_cnt       <= '0;
    end else if (clear) begin
      r_state     <= enable ? RUN : IDLE;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        IDLE:    if (enable) r_state <= RUN;
        RUN: begin
          if (HALT_ON_NEQ && w_mismatch) r_state <= HALT;
          else if (!enable)              r_state <= IDLE;
        end
        HALT:    r_state <= HALT;
        default: r_state <= IDLE;
      endcase

      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_neq   <= w_neq;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_mismatch && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_neq      = r_out_neq;
  assign mismatch_cnt = r_cnt;
  assign cnt_sat      = (r_cnt == CNT_MAX);
  assign halted       = (r_state == HALT);

`ifdef NEQ_STREAM_MONITOR_FIRST_CAPTURE_EN
  logic [N-1:0] r_first_a;
  logic [N-1:0] r_first_b;
  logic         r_first_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_a   <= '0;
      r_first_b   <= '0;
      r_first_vld <= 1'b0;
    end else if (clear) begin
      r_first_a   <= '0;
      r_first_b   <= '0;
      r_first_vld <= 1'b0;
    end else if (w_mismatch && !r_first_vld) begin
      r_first_a   <= a;
      r_first_b   <= b;
      r_first_vld <= 1'b1;
    end
  end

  assign first_a   = r_first_a;
  assign first_b   = r_first_b;
  assign first_vld = r_first_vld;
`endif

endmodule

// File: tb/tb_neq_stream_monitor.sv
// Directed bench for neq_stream_monitor: a vector table on the default
// configuration plus hand sequences for saturation, HALT, async reset and capture.
module tb_neq_stream_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       clear;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;

  always #5 clk = ~clk;

  // Default configuration (N=8, CNT_W=16, no halt)
  logic        d_in_ready, d_out_valid, d_out_neq, d_cnt_sat, d_halted;
  logic [15:0] d_cnt;
  // CNT_W=2 instance
  logic        s_in_ready, s_out_valid, s_out_neq, s_cnt_sat, s_halted;
  logic [1:0]  s_cnt;
  // HALT_ON_NEQ=1 instance
  logic        h_in_ready, h_out_valid, h_out_neq, h_cnt_sat, h_halted;
  logic [15:0] h_cnt;
`ifdef NEQ_STREAM_MONITOR_FIRST_CAPTURE_EN
  logic [7:0]  d_first_a, d_first_b, s_first_a, s_first_b, h_first_a, h_first_b;
  logic        d_first_vld, s_first_vld, h_first_vld;
`endif

  neq_stream_monitor #(.N(8), .CNT_W(16), .HALT_ON_NEQ(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .in_valid(in_valid), .in_ready(d_in_ready), .a(a), .b(b),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_neq(d_out_neq),
    .mismatch_cnt(d_cnt), .cnt_sat(d_cnt_sat), .halted(d_halted)
`ifdef NEQ_STREAM_MONITOR_FIRST_CAPTURE_EN
    , .first_a(d_first_a), .first_b(d_first_b), .first_vld(d_first_vld)
`endif
  );

  neq_stream_monitor #(.N(8), .CNT_W(2), .HALT_ON_NEQ(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_neq(s_out_neq),
    .mismatch_cnt(s_cnt), .cnt_sat(s_cnt_sat), .halted(s_halted)
`ifdef NEQ_STREAM_MONITOR_FIRST_CAPTURE_EN
    , .first_a(s_first_a), .first_b(s_first_b), .first_vld(s_first_vld)
`endif
  );

  neq_stream_monitor #(.N(8), .CNT_W(16), .HALT_ON_NEQ(1'b1)) u_halt (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .in_valid(in_valid), .in_ready(h_in_ready), .a(a), .b(b),
    .out_valid(h_out_valid), .out_ready(out_ready), .out_neq(h_out_neq),
    .mismatch_cnt(h_cnt), .cnt_sat(h_cnt_sat), .halted(h_halted)
`ifdef NEQ_STREAM_MONITOR_FIRST_CAPTURE_EN
    , .first_a(h_first_a), .first_b(h_first_b), .first_vld(h_first_vld)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        en;
    logic        clr;
    logic        iv;
    logic [7:0]  va;
    logic [7:0]  vb;
    logic        ordy;
    logic        exp_ir;
    logic        exp_ov;
    logic        exp_neq;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic clr, input logic iv,
                     input logic [7:0] va, input logic [7:0] vb, input logic ordy,
                     input logic ir, input logic ov, input logic nq, input logic [15:0] cnt);
    vec_t v;
    v.en = en; v.clr = clr; v.iv = iv; v.va = va; v.vb = vb; v.ordy = ordy;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_neq = nq; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; a = '0; b = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; a = '0; b = '0;

    // Each row: inputs applied mid-cycle, expected values seen before the next edge.
    //   en clr iv  a      b      ordy | ir ov neq cnt
    add(1, 0, 0, 8'hxx, 8'hxx, 1,   0, 0, 0, 16'd0); // IDLE, enable rising
    add(1, 0, 1, 8'h5A, 8'h5A, 1,   1, 0, 0, 16'd0); // equal pair accepted
    add(1, 0, 1, 8'h5A, 8'h5B, 1,   1, 1, 0, 16'd0); // mismatch accepted
    add(1, 0, 1, 8'h01, 8'h02, 1,   1, 1, 1, 16'd1); // mismatch, then back-pressure
    for (int i = 0; i < 5; i++)
      add(1, 0, 1, 8'h07, 8'h07, 0, 0, 1, 1, 16'd2); // held for 5 cycles
    add(1, 0, 1, 8'h07, 8'h07, 1,   1, 1, 1, 16'd2); // release: accepted same cycle
    add(1, 0, 0, 8'hxx, 8'hxx, 1,   1, 1, 0, 16'd2); // X operands, no valid
    add(1, 0, 0, 8'hxx, 8'hxx, 1,   1, 0, 0, 16'd2); // drained
    add(0, 0, 1, 8'h03, 8'h04, 1,   1, 0, 0, 16'd2); // enable falls, still RUN this cycle
    add(0, 0, 1, 8'h03, 8'h04, 0,   0, 1, 1, 16'd3); // IDLE, pending result held
    add(0, 0, 0, 8'hxx, 8'hxx, 1,   0, 1, 1, 16'd3); // pending drains
    add(0, 0, 0, 8'hxx, 8'hxx, 1,   0, 0, 1, 16'd3);
    add(1, 0, 0, 8'hxx, 8'hxx, 1,   0, 0, 1, 16'd3); // re-enable
    add(1, 0, 1, 8'h01, 8'h00, 0,   1, 0, 1, 16'd3); // accept, leave pending
    add(1, 1, 1, 8'h09, 8'h08, 1,   0, 1, 1, 16'd4); // clear with valid + pending
    add(1, 0, 0, 8'hxx, 8'hxx, 1,   1, 0, 1, 16'd0); // discarded, counter zeroed

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset in_ready",  d_in_ready,  0);
    check("reset out_valid", d_out_valid, 0);
    check("reset out_neq",   d_out_neq,   0);
    check("reset cnt",       d_cnt,       0);
    check("reset cnt_sat",   d_cnt_sat,   0);
    check("reset halted",    d_halted,    0);

    foreach (vecs[i]) begin
      @(negedge clk);
      enable = vecs[i].en; clear = vecs[i].clr; in_valid = vecs[i].iv;
      a = vecs[i].va; b = vecs[i].vb; out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d in_ready", i),  d_in_ready,  vecs[i].exp_ir);
      check($sformatf("vec%0d out_valid", i), d_out_valid, vecs[i].exp_ov);
      check($sformatf("vec%0d out_neq", i),   d_out_neq,   vecs[i].exp_neq);
      check($sformatf("vec%0d cnt", i),       d_cnt,       vecs[i].exp_cnt);
    end

    // Asynchronous reset with a result pending
    @(negedge clk);
    enable = 1'b1; clear = 1'b0; in_valid = 1'b1; a = 8'h01; b = 8'h02; out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("pre-reset out_valid", d_out_valid, 1);
    check("pre-reset cnt",       d_cnt,       1);
    #1 rst_n = 1'b0;
    #1;
    check("async rst in_ready",  d_in_ready,  0);
    check("async rst out_valid", d_out_valid, 0);
    check("async rst out_neq",   d_out_neq,   0);
    check("async rst cnt",       d_cnt,       0);
    check("async rst halted",    d_halted,    0);

    // Saturation with CNT_W=2
    do_reset();
    @(negedge clk);
    enable = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'(k); b = 8'(k + 1);
      @(posedge clk);
      #1;
      check($sformatf("sat cnt k%0d", k), s_cnt, (k < 3) ? k + 1 : 3);
      check($sformatf("sat flag k%0d", k), s_cnt_sat, (k >= 2) ? 1 : 0);
    end
    @(negedge clk);
    in_valid = 1'b0;

    // HALT_ON_NEQ=1
    do_reset();
    @(negedge clk);
    enable = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = 8'h10; b = 8'h10;
    #1 check("halt p1 in_ready", h_in_ready, 1);
    @(negedge clk);
    a = 8'h10; b = 8'h11;
    #1 check("halt p2 in_ready", h_in_ready, 1);
    @(posedge clk);
    #1;
    check("halt halted",    h_halted,    1);
    check("halt out_valid", h_out_valid, 1);
    check("halt out_neq",   h_out_neq,   1);
    check("halt cnt",       h_cnt,       1);
    @(negedge clk);
    a = 8'h22; b = 8'h22;
    #1 check("halt p3 in_ready", h_in_ready, 0);
    @(posedge clk);
    #1;
    check("halt drained",    h_out_valid, 0);
    check("halt cnt frozen", h_cnt,       1);
    check("halt stays",      h_halted,    1);
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b1;
    @(posedge clk);
    #1;
    check("clear leaves halt", h_halted, 0);
    check("clear zeroes cnt",  h_cnt,    0);
    @(negedge clk);
    clear = 1'b0;
    #1 check("clear back to RUN", h_in_ready, 1);

`ifdef NEQ_STREAM_MONITOR_FIRST_CAPTURE_EN
    do_reset();
    @(negedge clk);
    enable = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = 8'hAA; b = 8'hAB;
    @(negedge clk);
    a = 8'h33; b = 8'h34;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("first_a",   d_first_a,   8'hAA);
    check("first_b",   d_first_b,   8'hAB);
    check("first_vld", d_first_vld, 1);
    check("first cnt", d_cnt,       2);
    rst_n = 1'b0;
    #1;
    check("rst first_a",   d_first_a,   0);
    check("rst first_b",   d_first_b,   0);
    check("rst first_vld", d_first_vld, 0);
    check("rst out_valid", d_out_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
